// File: rtl/fft_pkg.sv
// Shared types and sizes for the radix-2 butterfly output path.
package fft_pkg;
  localparam int WIDTH = 10;
  localparam int NUM   = 16;
  localparam int DATA  = 512;
  localparam int COUNT = DATA / NUM;
  localparam int HALF  = COUNT / 2;
  localparam int AW    = $clog2(HALF);

  typedef logic signed [WIDTH-1:0] lane_t;
  typedef lane_t [NUM-1:0] lane_vec_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/bfly_line_buf.sv
// Line buffer holding one frame's difference-path beats until the sum burst is out.
module bfly_line_buf
  import fft_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  addr_t     waddr,
  input  lane_vec_t wdata_re,
  input  lane_vec_t wdata_im,
  input  addr_t     raddr,
  output lane_vec_t rdata_re,
  output lane_vec_t rdata_im
);
  lane_vec_t mem_re_r [HALF];
  lane_vec_t mem_im_r [HALF];

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re_r[waddr] <= wdata_re;
      mem_im_r[waddr] <= wdata_im;
    end
  end

  assign rdata_re = mem_re_r[raddr];
  assign rdata_im = mem_im_r[raddr];
endmodule

// File: rtl/bfly_out_sched.sv
// Re-serialises butterfly sum/difference beats: sum beats pass through, difference
// beats are buffered and replayed back-to-back after the sum burst.
module bfly_out_sched
  import fft_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      valid_in,
  input  lane_vec_t din1_re,
  input  lane_vec_t din1_im,
  input  lane_vec_t din2_re,
  input  lane_vec_t din2_im,
  input  logic      clr_err,
  output lane_vec_t dout_re,
  output lane_vec_t dout_im,
  output logic      valid_out,
  output logic      sop,
  output logic      eop,
  output logic      busy,
  output logic      ovf_err
);
  localparam addr_t LAST = addr_t'(HALF - 1);

  state_t    state_r;
  addr_t     wr_cnt_r;
  addr_t     rd_cnt_r;
  lane_vec_t dout_re_r;
  lane_vec_t dout_im_r;
  logic      valid_out_r;
  logic      sop_r;
  logic      eop_r;
  logic      ovf_err_r;
  logic      we_s;
  lane_vec_t rd_re_s;
  lane_vec_t rd_im_s;

  // Difference beats are captured whenever a beat is accepted (IDLE or PASS)
  always_comb begin
    we_s = 1'b0;
    if (valid_in && (state_r != DRAIN)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  bfly_line_buf u_line_buf (
    .clk      (clk),
    .we       (we_s),
    .waddr    (wr_cnt_r),
    .wdata_re (din2_re),
    .wdata_im (din2_im),
    .raddr    (rd_cnt_r),
    .rdata_re (rd_re_s),
    .rdata_im (rd_im_s)
  );

  // Scheduler FSM with counters, registered outputs and sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      wr_cnt_r    <= addr_t'(0);
      rd_cnt_r    <= addr_t'(0);
      dout_re_r   <= lane_vec_t'(0);
      dout_im_r   <= lane_vec_t'(0);
      valid_out_r <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      ovf_err_r   <= 1'b0;
    end else begin
      valid_out_r <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      if (clr_err) begin
        ovf_err_r <= 1'b0;
      end
      case (state_r)
        IDLE, PASS: begin
          if (valid_in) begin
            dout_re_r   <= din1_re;
            dout_im_r   <= din1_im;
            valid_out_r <= 1'b1;
            sop_r       <= (state_r == IDLE);
            if (wr_cnt_r == LAST) begin
              wr_cnt_r <= addr_t'(0);
              state_r  <= DRAIN;
            end else begin
              wr_cnt_r <= wr_cnt_r + addr_t'(1);
              state_r  <= PASS;
            end
          end
        end
        DRAIN: begin
          // Inputs are not accepted here; any beat offered is lost and flagged
          if (valid_in) begin
            ovf_err_r <= 1'b1;
          end
          dout_re_r   <= rd_re_s;
          dout_im_r   <= rd_im_s;
          valid_out_r <= 1'b1;
          eop_r       <= (rd_cnt_r == LAST);
          if (rd_cnt_r == LAST) begin
            rd_cnt_r <= addr_t'(0);
            state_r  <= IDLE;
          end else begin
            rd_cnt_r <= rd_cnt_r + addr_t'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dout_re   = dout_re_r;
  assign dout_im   = dout_im_r;
  assign valid_out = valid_out_r;
  assign sop       = sop_r;
  assign eop       = eop_r;
  assign ovf_err   = ovf_err_r;
  assign busy      = (state_r != IDLE);
endmodule

// File: tb/tb_bfly_out_sched.sv
// Randomised bench for bfly_out_sched against a cycle-timeline reference model.
module tb_bfly_out_sched;
  import fft_pkg::*;

  typedef logic [NUM*WIDTH-1:0] word_t;
  typedef struct {
    lane_vec_t re;
    lane_vec_t im;
    bit        sop;
    bit        eop;
  } beat_t;

  logic      clk = 1'b0;
  logic      rstn = 1'b0;
  logic      valid_in = 1'b0;
  logic      clr_err = 1'b0;
  lane_vec_t din1_re, din1_im, din2_re, din2_im;
  lane_vec_t dout_re, dout_im;
  logic      valid_out, sop, eop, busy, ovf_err;

  always #5 clk = ~clk;

  bfly_out_sched dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .clr_err(clr_err), .dout_re(dout_re), .dout_im(dout_im),
    .valid_out(valid_out), .sop(sop), .eop(eop), .busy(busy), .ovf_err(ovf_err)
  );

  int        n_tests = 0;
  int        n_fail = 0;
  int        edge_c = 0;
  // Expected output beats keyed by the clock edge after which they are visible
  beat_t     exp_q [int];
  lane_vec_t hold_re [$];
  lane_vec_t hold_im [$];
  int        nacc = 0;
  int        last_acc = -1000;
  bit        m_ovf = 1'b0;
  lane_vec_t last_re, last_im;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %h expected %h", tag, edge_c, obs, exp);
    end
  endtask

  function automatic lane_vec_t fill(input int v);
    lane_vec_t r;
    for (int i = 0; i < NUM; i++) r[i] = lane_t'(v);
    return r;
  endfunction

  function automatic lane_vec_t rnd();
    lane_vec_t r;
    for (int i = 0; i < NUM; i++) r[i] = lane_t'($urandom);
    return r;
  endfunction

  // A completed frame occupies the HALF edges after its last accept for replay
  task automatic model_edge();
    bit in_drain;
    in_drain = (edge_c >= last_acc + 1) && (edge_c <= last_acc + HALF);
    if (valid_in && in_drain) m_ovf = 1'b1;
    else if (clr_err) m_ovf = 1'b0;
    if (valid_in && !in_drain) begin
      exp_q[edge_c] = '{din1_re, din1_im, (nacc == 0), 1'b0};
      hold_re.push_back(din2_re);
      hold_im.push_back(din2_im);
      nacc++;
      if (nacc == HALF) begin
        for (int i = 0; i < HALF; i++)
          exp_q[edge_c + 1 + i] = '{hold_re[i], hold_im[i], 1'b0, (i == HALF - 1)};
        hold_re.delete();
        hold_im.delete();
        nacc = 0;
        last_acc = edge_c;
      end
    end
  endtask

  task automatic check_outputs();
    bit busy_e;
    busy_e = (nacc > 0) || (edge_c >= last_acc && edge_c < last_acc + HALF);
    if (exp_q.exists(edge_c)) begin
      chk("valid", word_t'(valid_out), word_t'(1'b1));
      chk("sop", word_t'(sop), word_t'(exp_q[edge_c].sop));
      chk("eop", word_t'(eop), word_t'(exp_q[edge_c].eop));
      chk("dout_re", word_t'(dout_re), word_t'(exp_q[edge_c].re));
      chk("dout_im", word_t'(dout_im), word_t'(exp_q[edge_c].im));
      last_re = exp_q[edge_c].re;
      last_im = exp_q[edge_c].im;
      exp_q.delete(edge_c);
    end else begin
      chk("valid_idle", word_t'(valid_out), word_t'(1'b0));
      chk("sop_idle", word_t'(sop), word_t'(1'b0));
      chk("eop_idle", word_t'(eop), word_t'(1'b0));
      chk("hold_re", word_t'(dout_re), word_t'(last_re));
      chk("hold_im", word_t'(dout_im), word_t'(last_im));
    end
    chk("busy", word_t'(busy), word_t'(busy_e));
    chk("ovf_err", word_t'(ovf_err), word_t'(m_ovf));
  endtask

  task automatic step(input bit v, input lane_vec_t a, input lane_vec_t b,
                      input lane_vec_t c, input lane_vec_t d, input bit clr);
    valid_in = v;
    din1_re = a; din1_im = b; din2_re = c; din2_im = d;
    clr_err = clr;
    @(posedge clk);
    edge_c++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd(), rnd(), rnd(), rnd(), 1'b0);
  endtask

  task automatic rnd_frame();
    for (int i = 0; i < HALF; i++) step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock
  task automatic do_reset();
    valid_in = 1'b0;
    clr_err = 1'b0;
    rstn = 1'b0;
    #2;
    exp_q.delete();
    hold_re.delete();
    hold_im.delete();
    nacc = 0;
    last_acc = -1000;
    m_ovf = 1'b0;
    last_re = lane_vec_t'(0);
    last_im = lane_vec_t'(0);
    chk("rst_valid", word_t'(valid_out), word_t'(1'b0));
    chk("rst_sop", word_t'(sop), word_t'(1'b0));
    chk("rst_eop", word_t'(eop), word_t'(1'b0));
    chk("rst_busy", word_t'(busy), word_t'(1'b0));
    chk("rst_ovf", word_t'(ovf_err), word_t'(1'b0));
    chk("rst_dout_re", word_t'(dout_re), word_t'(0));
    chk("rst_dout_im", word_t'(dout_im), word_t'(0));
    @(posedge clk);
    edge_c++;
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    din1_re = lane_vec_t'(0); din1_im = lane_vec_t'(0);
    din2_re = lane_vec_t'(0); din2_im = lane_vec_t'(0);
    #3;
    do_reset();

    // Single frame with recognisable lane values
    for (int k = 0; k < HALF; k++)
      step(1'b1, fill(k), fill(k + 50), fill(-k), fill(k + 100), 1'b0);
    idle(20);

    // Alternating valid_in over 32 cycles
    for (int i = 0; i < 2 * HALF; i++)
      step((i % 2) == 0, rnd(), rnd(), rnd(), rnd(), 1'b0);
    idle(20);

    // Back-to-back frames: next frame starts the cycle after eop
    rnd_frame();
    idle(HALF);
    rnd_frame();
    idle(20);

    // Overrun during drain, then clear
    rnd_frame();
    idle(4);
    step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
    idle(15);
    step(1'b0, rnd(), rnd(), rnd(), rnd(), 1'b1);
    idle(3);

    // Reset with rd_cnt at 7, then a clean frame
    rnd_frame();
    idle(7);
    do_reset();
    rnd_frame();
    idle(20);

    // Extreme sample values
    for (int k = 0; k < HALF; k++)
      step(1'b1, fill(511), fill(-512), fill(-512), fill(511), 1'b0);
    idle(20);

    // Random traffic with random clears and overruns
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, rnd(), rnd(), rnd(), rnd(),
           $urandom_range(0, 15) == 0);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
